gauss_frame_sequencer: RTL and testbench
========================================

// Module: gauss_frame_sequencer
// PURPOSE
//  Parametrised control sequencer for the Gaussian smoothing pipeline (buffer -> shifter -> hold ->
//  multiplier -> normaliser -> output packer). Drives per-word phase enables over a frame of
//  FRAME_WORDS 64-bit SRAM words. Adds word-boundary stall, continuous-frame mode, configurable
//  prefetch (get_next) point and a frame_done pulse.
// PARAMETERS
//  FRAME_WORDS   131072  words per frame (>=2)
//  WORD_PERIOD   20      cycles per word (>=4)
//  POP_START     1       phase of pop_buffer_en window start
//  POP_LEN       2       pop window length, cycles
//  CALC_START    3       phase of shift/hold/mult/norm window start
//  CALC_LEN      2       calc window length, cycles
//  PUT_START     18      phase of put_data_en window start
//  PUT_LEN       2       put window length, cycles
//  PREFETCH_WORD 104857  word index at which get_next pulses (~4/5 of frame)
//  Legal iff POP_START+POP_LEN<=CALC_START, CALC_START+CALC_LEN<=PUT_START,
//  PUT_START+PUT_LEN<=WORD_PERIOD, PREFETCH_WORD<FRAME_WORDS. Elaboration $error otherwise.
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  start_en       in   1   level; starts a frame when IDLE
//  cont_mode      in   1   1 = start next frame immediately after frame_done
//  stall          in   1   downstream not ready; sampled at phase 0 only
//  pop_buffer_en  out  1   BufferBlock pop enable
//  shift_en       out  1   ShifterBlock enable
//  hold_en        out  1   HoldBlock enable
//  mult_en        out  1   multiplier start enable
//  norm_en        out  1   normaliser start enable
//  put_data_en    out  1   output packer write enable
//  get_next       out  1   1-cycle prefetch request for next SRAM fill
//  frame_done     out  1   1-cycle pulse, last cycle of last word
//  busy           out  1   1 while state == RUN
//  word_idx       out  W   current word, W = $clog2(FRAME_WORDS)
// BEHAVIOUR
//  - Reset: all outputs 0, word_idx 0, phase 0, state IDLE; applies mid-frame with no completion.
//  - States: IDLE -> RUN when start_en==1 (first RUN cycle is phase 0, word 0).
//    RUN -> IDLE at frame end if cont_mode==0; RUN -> RUN (word 0, phase 0) if cont_mode==1.
//    start_en ignored in RUN.
//  - Phase counter 0..WORD_PERIOD-1. Exception: at phase 0, if stall==1, hold phase 0 and
//    word_idx; all enables stay 0. Stall at phase != 0 has no effect until the next phase 0.
//  - Enables are registered decodes of phase, high for phase in [X_START, X_START+X_LEN):
//    pop_buffer_en; shift_en=hold_en=mult_en=norm_en (calc window); put_data_en.
//    Exactly one pop/calc/put window per word.
//  - Phase WORD_PERIOD-1: phase->0 and word_idx++. On the last word, frame_done=1 that cycle;
//    word_idx wraps to 0.
//  - get_next=1 for one cycle at phase 0 of word PREFETCH_WORD (first non-stalled cycle).
//    Fires once per frame.
//  - Frame length with no stalls: exactly FRAME_WORDS*WORD_PERIOD cycles from leaving IDLE.
//  - cont_mode sampled only at frame end. Dropping start_en mid-frame does not abort.
//  - Counters never overflow: word_idx W bits, phase $clog2(WORD_PERIOD) bits.
// STRUCTURE
//  - Package gauss_seq_pkg: state enum {IDLE, RUN}, default timing localparams,
//    pixels-per-word (8) and lane count (2) constants shared with datapath blocks.
//  - Sub-module gauss_phase_timer: phase counter, stall-at-boundary logic, registered window
//    decodes. Top holds FSM, word counter, prefetch/done pulses.
// TESTING (FRAME_WORDS=4, WORD_PERIOD=20, PREFETCH_WORD=3, other defaults)
//  - start_en=1 one cycle -> pop at phases 1-2, calc 3-4, put 18-19 per word;
//    frame_done after 80 cycles; busy then falls.
//  - stall=1 for 5 cycles spanning word 1 phase 0 -> word 1 windows shift 5 cycles later;
//    frame length 85 cycles.
//  - stall asserted at phase 10 and released at phase 15 -> no effect on timing.
//  - get_next -> exactly one pulse at word 3 phase 0 (cycle 60); none in a second frame
//    before its own word 3.
//  - cont_mode=1 -> two back-to-back frames, 160 cycles, busy stays 1,
//    frame_done pulses at cycles 79 and 159.
//  - reset at word 2 phase 4 -> next cycle: all outputs 0, IDLE, word_idx 0; no frame_done.

Source files
------------

// File: rtl/gauss_seq_pkg.sv
// Shared types and constants for the Gaussian smoothing control path.
package gauss_seq_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } seq_state_e;

  // Default frame timing.
  localparam int unsigned DefFrameWords   = 131072;
  localparam int unsigned DefWordPeriod   = 20;
  localparam int unsigned DefPopStart     = 1;
  localparam int unsigned DefPopLen       = 2;
  localparam int unsigned DefCalcStart    = 3;
  localparam int unsigned DefCalcLen      = 2;
  localparam int unsigned DefPutStart     = 18;
  localparam int unsigned DefPutLen       = 2;
  localparam int unsigned DefPrefetchWord = 104857;

  // Datapath geometry shared with the buffer/shifter/multiplier blocks.
  localparam int unsigned PixelsPerWord = 8;
  localparam int unsigned LaneCount     = 2;

  // True when ph lies in the half-open window [st, st + len).
  function automatic logic in_window(input int unsigned ph, input int unsigned st,
                                     input int unsigned len);
    return (ph >= st) && (ph < st + len);
  endfunction

endpackage

// File: rtl/gauss_phase_timer.sv
// Per-word phase counter with phase-0 stall and registered enable windows.
module gauss_phase_timer
  import gauss_seq_pkg::*;
#(
  parameter int unsigned WORD_PERIOD = DefWordPeriod,
  parameter int unsigned POP_START   = DefPopStart,
  parameter int unsigned POP_LEN     = DefPopLen,
  parameter int unsigned CALC_START  = DefCalcStart,
  parameter int unsigned CALC_LEN    = DefCalcLen,
  parameter int unsigned PUT_START   = DefPutStart,
  parameter int unsigned PUT_LEN     = DefPutLen
) (
  input  logic clk,
  input  logic reset,
  input  logic run_q_i,
  input  logic run_d_i,
  input  logic stall_i,
  output logic word_end_o,
  output logic boundary_go_o,
  output logic last_next_o,
  output logic pop_en_o,
  output logic calc_en_o,
  output logic put_en_o
);

  localparam int unsigned PW = $clog2(WORD_PERIOD);
  localparam logic [PW-1:0] PhaseLast = PW'(WORD_PERIOD - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          pop_q, pop_d;
  logic          calc_q, calc_d;
  logic          put_q, put_d;
  logic          at_zero, at_last;

  assign at_zero = (phase_q == '0);
  assign at_last = (phase_q == PhaseLast);

  // Word boundary reached this cycle; phase 0 leaves only when not stalled.
  assign word_end_o    = run_q_i && at_last;
  assign boundary_go_o = run_q_i && at_zero && !stall_i;

  // Next phase and window decodes of that next phase, so outputs line up with phase_q.
  always_comb begin
    phase_d = phase_q;
    if (!run_q_i || at_last) begin
      phase_d = '0;
    end else if (!(at_zero && stall_i)) begin
      phase_d = phase_q + 1'b1;
    end
    pop_d       = run_d_i && in_window(32'(phase_d), POP_START, POP_LEN);
    calc_d      = run_d_i && in_window(32'(phase_d), CALC_START, CALC_LEN);
    put_d       = run_d_i && in_window(32'(phase_d), PUT_START, PUT_LEN);
    last_next_o = run_d_i && (phase_d == PhaseLast);
  end

  // Phase and enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      pop_q   <= 1'b0;
      calc_q  <= 1'b0;
      put_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pop_q   <= pop_d;
      calc_q  <= calc_d;
      put_q   <= put_d;
    end
  end

  assign pop_en_o  = pop_q;
  assign calc_en_o = calc_q;
  assign put_en_o  = put_q;

endmodule

// File: rtl/gauss_frame_sequencer.sv
// Frame-level sequencer: IDLE/RUN FSM, word counter, prefetch and frame-done pulses.
module gauss_frame_sequencer
  import gauss_seq_pkg::*;
#(
  parameter int unsigned FRAME_WORDS   = DefFrameWords,
  parameter int unsigned WORD_PERIOD   = DefWordPeriod,
  parameter int unsigned POP_START     = DefPopStart,
  parameter int unsigned POP_LEN       = DefPopLen,
  parameter int unsigned CALC_START    = DefCalcStart,
  parameter int unsigned CALC_LEN      = DefCalcLen,
  parameter int unsigned PUT_START     = DefPutStart,
  parameter int unsigned PUT_LEN       = DefPutLen,
  parameter int unsigned PREFETCH_WORD = DefPrefetchWord,
  localparam int unsigned W            = $clog2(FRAME_WORDS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_en,
  input  logic         cont_mode,
  input  logic         stall,
  output logic         pop_buffer_en,
  output logic         shift_en,
  output logic         hold_en,
  output logic         mult_en,
  output logic         norm_en,
  output logic         put_data_en,
  output logic         get_next,
  output logic         frame_done,
  output logic         busy,
  output logic [W-1:0] word_idx
);

  if (FRAME_WORDS < 2 || WORD_PERIOD < 4 ||
      POP_START + POP_LEN > CALC_START ||
      CALC_START + CALC_LEN > PUT_START ||
      PUT_START + PUT_LEN > WORD_PERIOD ||
      PREFETCH_WORD >= FRAME_WORDS) begin : gen_bad_params
    $error("gauss_frame_sequencer: illegal timing parameters");
  end

  localparam logic [W-1:0] LastWord     = W'(FRAME_WORDS - 1);
  localparam logic [W-1:0] PrefetchWord = W'(PREFETCH_WORD);

  seq_state_e   state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic         frame_done_q, frame_done_d;
  logic         run_q, run_d;
  logic         word_end, boundary_go, last_next, calc_en;

  assign run_q = (state_q == StRun);
  assign run_d = (state_d == StRun);

  gauss_phase_timer #(
    .WORD_PERIOD (WORD_PERIOD),
    .POP_START   (POP_START),
    .POP_LEN     (POP_LEN),
    .CALC_START  (CALC_START),
    .CALC_LEN    (CALC_LEN),
    .PUT_START   (PUT_START),
    .PUT_LEN     (PUT_LEN)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .run_q_i       (run_q),
    .run_d_i       (run_d),
    .stall_i       (stall),
    .word_end_o    (word_end),
    .boundary_go_o (boundary_go),
    .last_next_o   (last_next),
    .pop_en_o      (pop_buffer_en),
    .calc_en_o     (calc_en),
    .put_en_o      (put_data_en)
  );

  // FSM next state and word counter; start_en only matters in idle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      StIdle: begin
        if (start_en) begin
          state_d = StRun;
          word_d  = '0;
        end
      end
      StRun: begin
        if (word_end) begin
          if (word_q == LastWord) begin
            word_d = '0;
            if (!cont_mode) begin
              state_d = StIdle;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        word_d  = '0;
      end
    endcase
  end

  // Registered frame-done: next cycle is the last phase of the last word.
  always_comb begin
    frame_done_d = last_next && (word_d == LastWord);
  end

  // State, word and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      word_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Prefetch fires on the cycle that leaves phase 0 of the prefetch word, so stalls
  // at that boundary cannot produce a second pulse.
  assign get_next   = run_q && (word_q == PrefetchWord) && boundary_go;
  assign frame_done = frame_done_q;
  assign busy       = run_q;
  assign word_idx   = word_q;
  assign shift_en   = calc_en;
  assign hold_en    = calc_en;
  assign mult_en    = calc_en;
  assign norm_en    = calc_en;

endmodule

// File: tb/tb_gauss_frame_sequencer.sv
// Scoreboard bench for gauss_frame_sequencer with a small-frame configuration.
module tb_gauss_frame_sequencer;

  localparam int unsigned FW = 4;
  localparam int unsigned WP = 20;
  localparam int unsigned PF = 3;
  localparam int unsigned PopS = 1, PopL = 2, CalcS = 3, CalcL = 2, PutS = 18, PutL = 2;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         reset, start_en, cont_mode, stall;
  logic         pop_buffer_en, shift_en, hold_en, mult_en, norm_en, put_data_en;
  logic         get_next, frame_done, busy;
  logic [W-1:0] word_idx;

  always #5 clk = ~clk;

  gauss_frame_sequencer #(
    .FRAME_WORDS   (FW),
    .WORD_PERIOD   (WP),
    .POP_START     (PopS),
    .POP_LEN       (PopL),
    .CALC_START    (CalcS),
    .CALC_LEN      (CalcL),
    .PUT_START     (PutS),
    .PUT_LEN       (PutL),
    .PREFETCH_WORD (PF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_en      (start_en),
    .cont_mode     (cont_mode),
    .stall         (stall),
    .pop_buffer_en (pop_buffer_en),
    .shift_en      (shift_en),
    .hold_en       (hold_en),
    .mult_en       (mult_en),
    .norm_en       (norm_en),
    .put_data_en   (put_data_en),
    .get_next      (get_next),
    .frame_done    (frame_done),
    .busy          (busy),
    .word_idx      (word_idx)
  );

  typedef struct packed {
    logic         pop;
    logic [3:0]   calc;
    logic         put;
    logic         get_next;
    logic         frame_done;
    logic         busy;
    logic [W-1:0] word;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: where the frame is, in plain integers.
  bit m_run;
  int m_word, m_ph;

  function automatic obs_t model_out(input logic stl);
    obs_t e;
    e.busy       = m_run;
    e.pop        = m_run && m_ph >= PopS && m_ph < PopS + PopL;
    e.calc       = {4{m_run && m_ph >= CalcS && m_ph < CalcS + CalcL}};
    e.put        = m_run && m_ph >= PutS && m_ph < PutS + PutL;
    e.get_next   = m_run && m_ph == 0 && m_word == PF && !stl;
    e.frame_done = m_run && m_ph == WP - 1 && m_word == FW - 1;
    e.word       = W'(m_word);
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic cm, input logic stl);
    if (rst) begin
      m_run = 0; m_word = 0; m_ph = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_word = 0; m_ph = 0;
      end
    end else if (m_ph == 0 && stl) begin
      m_ph = 0;
    end else if (m_ph == WP - 1) begin
      m_ph = 0;
      if (m_word == FW - 1) begin
        m_word = 0;
        m_run  = cm;
      end else begin
        m_word++;
      end
    end else begin
      m_ph++;
    end
  endtask

  // One clock: advance the model on the edge, then apply new inputs and queue expectation.
  task automatic drive(input logic rst, input logic st, input logic cm, input logic stl);
    @(posedge clk);
    model_step(reset, start_en, cont_mode, stall);
    #1;
    reset = rst; start_en = st; cont_mode = cm; stall = stl;
    exp_q.push_back(model_out(stl));
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pop: pop_buffer_en, calc: {shift_en, hold_en, mult_en, norm_en},
              put: put_data_en, get_next: get_next, frame_done: frame_done,
              busy: busy, word: word_idx};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t {pop,calc4,put,get_next,frame_done,busy,word} got=%b want=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start_en = 1'b0; cont_mode = 1'b0; stall = 1'b0;
    m_run = 0; m_word = 0; m_ph = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Single frame, no stalls; start_en for one cycle.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 90; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Stall covering word 1 phase 0 for five cycles, then one mid-word stall.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 95; i++) drive(1'b0, 1'b0, 1'b0, (i >= 20 && i < 25));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 90; i++) drive(1'b0, 1'b0, 1'b0, (i >= 30 && i < 35));

    // Two back-to-back frames in continuous mode; start_en held high throughout.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 170; i++) drive(1'b0, 1'b1, (i < 120), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at word 2 phase 4.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) drive((i == 44), 1'b0, 1'b0, 1'b0);

    // Random traffic.
    begin
      logic cm;
      cm = 1'b0;
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(99) < 5) cm = ~cm;
        drive(($urandom_range(199) == 0), ($urandom_range(99) < 10), cm,
              ($urandom_range(99) < 30));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
